// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue/retire stage that feeds a combinational ALU.
// Accepts MIPS-format instruction words over valid/ready and reads rs/rt from a
// 32x32 register file. It registers the decoded fields toward the ALU and writes
// the ALU result back on the following edge.
// Optional feature: define ALU_ISSUE_FWD_EN to forward RESULT into hazard
// operands. Without it, a read-after-write hazard stalls the stage for one cycle.
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [5:0]       opcode,
    output logic [31:0]      rs_val,
    output logic [31:0]      rt_val,
    output logic [4:0]       shamt,
    output logic [5:0]       func,
    output logic [15:0]      raw_val,
    output logic             issue_valid,
    input  logic [31:0]      result,
    input  logic             sig_b,
    output logic             br_taken,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic [31:0] rf [32];
    logic [4:0]  rt_idx;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  live_dst;
    logic        live_branch;
    logic        live_wen;
    logic        haz_rs;
    logic        haz_rt;
    logic        stall;
    logic        accept;
    logic [31:0] op_rs;
    logic [31:0] op_rt;

    // Decode the live instruction's destination, and detect hazards against the incoming word.
    always_comb begin
        in_rs       = instr[25:21];
        in_rt       = instr[20:16];
        live_dst    = (opcode == 6'd0) ? raw_val[15:11] : rt_idx;
        live_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        live_wen    = issue_valid && !live_branch && (opcode != OP_SW) && (live_dst != 5'd0);
        haz_rs      = live_wen && (in_rs == live_dst);
        haz_rt      = live_wen && (in_rt == live_dst);
    end

    // Operand selection and stall: forward RESULT, or hold off one cycle until write-back lands.
    always_comb begin
        op_rs = rf[in_rs];
        op_rt = rf[in_rt];
        stall = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
        if (haz_rs) op_rs = result;
        if (haz_rt) op_rt = result;
`else
        stall = instr_valid && (haz_rs || haz_rt);
`endif
        instr_ready = rst_n && !stall;
        accept      = instr_valid && instr_ready;
    end

    // Field registers toward the ALU; they hold their values on edges without an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode      <= '0;
            rs_val      <= '0;
            rt_val      <= '0;
            shamt       <= '0;
            func        <= '0;
            raw_val     <= '0;
            rt_idx      <= '0;
            issue_valid <= 1'b0;
        end else begin
            issue_valid <= accept;
            if (accept) begin
                opcode  <= instr[31:26];
                rs_val  <= op_rs;
                rt_val  <= op_rt;
                shamt   <= instr[10:6];
                func    <= instr[5:0];
                raw_val <= instr[15:0];
                rt_idx  <= in_rt;
            end
        end
    end

    // Retire bookkeeping: branch outcome and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            br_taken <= issue_valid && live_branch && sig_b;
            if (issue_valid) retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Register file write-back; entry 0 is never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (live_wen) begin
            rf[live_dst] <= result;
        end
    end

    // Debug read port.
    always_comb begin
        dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage. The bench plays the ALU: it computes RESULT and
// SIG_B from the issued fields. Issued fields are checked through a scoreboard
// queue that is filled when a word is driven.
module tb_alu_issue_stage;

    localparam int CW = 8;
`ifdef ALU_ISSUE_FWD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [5:0]    opcode;
    logic [31:0]   rs_val;
    logic [31:0]   rt_val;
    logic [4:0]    shamt;
    logic [5:0]    func;
    logic [15:0]   raw_val;
    logic          issue_valid;
    logic [31:0]   result;
    logic          sig_b;
    logic          br_taken;
    logic [4:0]    dbg_addr;
    logic [31:0]   dbg_data;
    logic [CW-1:0] retire_cnt;
    logic          force_sig;

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] exp_cnt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
    } sb_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  dst;
        logic [31:0] dst_val;
        logic        br;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[8];

    alu_issue_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .rs_val(rs_val), .rt_val(rt_val),
        .shamt(shamt), .func(func), .raw_val(raw_val), .issue_valid(issue_valid),
        .result(result), .sig_b(sig_b), .br_taken(br_taken), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // ALU model
    always_comb begin
        result = '0;
        sig_b  = force_sig;
        case (opcode)
            6'h00: begin
                case (func)
                    6'h00:   result = rt_val << shamt;
                    6'h20:   result = rs_val + rt_val;
                    default: result = rs_val ^ rt_val;
                endcase
            end
            6'h08, 6'h2b: result = rs_val + {{16{raw_val[15]}}, raw_val};
            6'h04: begin
                result = rs_val - rt_val;
                sig_b  = (rs_val == rt_val);
            end
            6'h05: begin
                result = rs_val - rt_val;
                sig_b  = (rs_val != rt_val);
            end
            default: result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare the issued fields one step after each edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && issue_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got opcode 0x%02h, expected no issue", opcode);
            end else begin
                mon_e = sb_q.pop_front();
                check("issue_op_shamt_func", {15'd0, opcode, shamt, func},
                      {15'd0, mon_e.instr[31:26], mon_e.instr[10:6], mon_e.instr[5:0]});
                check("issue_raw", {16'd0, raw_val}, {16'd0, mon_e.instr[15:0]});
                check("issue_rs_val", rs_val, mon_e.rs);
                check("issue_rt_val", rt_val, mon_e.rt);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [31:0] ers, input logic [31:0] ert,
                        output int stalls);
        sb_t e;
        stalls      = 0;
        instr       = w;
        instr_valid = 1'b1;
        #2;
        while (!instr_ready && stalls < 6) begin
            @(posedge clk);
            #3;
            stalls++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got instr_ready=0 for %0d cycles, expected 1", stalls);
            instr_valid = 1'b0;
        end else begin
            e.instr = w;
            e.rs    = ers;
            e.rt    = ert;
            sb_q.push_back(e);
            exp_cnt++;
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        vecs[0] = '{32'h2002000C, 32'd0,  32'd0,  5'd2, 32'd12, 1'b0};
        vecs[1] = '{32'h00021840, 32'd0,  32'd12, 5'd3, 32'd24, 1'b0};
        vecs[2] = '{32'h20000005, 32'd0,  32'd0,  5'd0, 32'd0,  1'b0};
        vecs[3] = '{32'h20640003, 32'd24, 32'd0,  5'd4, 32'd27, 1'b0};
        vecs[4] = '{32'h00822820, 32'd27, 32'd12, 5'd5, 32'd39, 1'b0};
        vecs[5] = '{32'hAC450004, 32'd12, 32'd39, 5'd5, 32'd39, 1'b0};
        vecs[6] = '{32'h10420002, 32'd12, 32'd12, 5'd2, 32'd12, 1'b1};
        vecs[7] = '{32'h14430001, 32'd12, 32'd24, 5'd3, 32'd24, 1'b1};

        rst_n       = 1'b0;
        instr       = 32'h2002000C;
        instr_valid = 1'b1;
        dbg_addr    = 5'd2;
        force_sig   = 1'b0;
        exp_cnt     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_rt_val", rt_val, 32'd0);
        check("rst_raw", {16'd0, raw_val}, 32'd0);
        check("rst_br", {31'd0, br_taken}, 32'd0);
        check("rst_cnt", {24'd0, retire_cnt}, 32'd0);
        check("rst_dbg", dbg_data, 32'd0);
        instr_valid = 1'b0;
        rst_n       = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, instr_ready}, 32'd1);
        idle(1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].instr, vecs[i].rs, vecs[i].rt, st);
            check($sformatf("vec%0d_stall", i), st, 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_br", i), {31'd0, br_taken}, {31'd0, vecs[i].br});
            check($sformatf("vec%0d_cnt", i), {24'd0, retire_cnt}, {24'd0, exp_cnt});
            check($sformatf("vec%0d_idle_valid", i), {31'd0, issue_valid}, 32'd0);
            dbg_addr = vecs[i].dst;
            #1;
            check($sformatf("vec%0d_dst", i), dbg_data, vecs[i].dst_val);
        end

        // branch: taken for exactly one cycle, non-branch retire clears it even with SIG_B high
        send(32'h10000003, 32'd0, 32'd0, st);
        @(posedge clk);
        #1;
        check("beq_taken", {31'd0, br_taken}, 32'd1);
        @(posedge clk);
        #1;
        check("beq_one_cycle", {31'd0, br_taken}, 32'd0);
        force_sig = 1'b1;
        send(32'h20000001, 32'd0, 32'd0, st);
        @(posedge clk);
        #1;
        check("nonbranch_br", {31'd0, br_taken}, 32'd0);
        force_sig = 1'b0;
        send(32'h14000003, 32'd0, 32'd0, st);
        @(posedge clk);
        #1;
        check("bne_not_taken", {31'd0, br_taken}, 32'd0);
        check("branch_cnt", {24'd0, retire_cnt}, {24'd0, exp_cnt});

        // back-to-back dependent pairs
        send(32'h20060007, 32'd0, 32'd0, st);
        send(32'h00063880, 32'd0, 32'd7, st);
        check("dep_rt_stall", st, EXP_STALL);
        idle(2);
        dbg_addr = 5'd7;
        #1;
        check("dep_rt_dst", dbg_data, 32'd28);
        send(32'h20090005, 32'd0, 32'd0, st);
        send(32'h01205020, 32'd5, 32'd0, st);
        check("dep_rs_stall", st, EXP_STALL);
        idle(2);
        dbg_addr = 5'd10;
        #1;
        check("dep_rs_dst", dbg_data, 32'd5);
        send(32'h20000005, 32'd0, 32'd0, st);
        send(32'h00005820, 32'd0, 32'd0, st);
        check("zero_dst_no_stall", st, 0);
        idle(2);
        dbg_addr = 5'd0;
        #1;
        check("r0_reads_zero", dbg_data, 32'd0);
        check("pairs_cnt", {24'd0, retire_cnt}, {24'd0, exp_cnt});

        // counter wrap
        while (exp_cnt != {CW{1'b1}}) send(32'h20000001, 32'd0, 32'd0, st);
        @(posedge clk);
        #1;
        check("cnt_all_ones", {24'd0, retire_cnt}, 32'h0000_00FF);
        send(32'h20000001, 32'd0, 32'd0, st);
        @(posedge clk);
        #1;
        check("cnt_wrap", {24'd0, retire_cnt}, 32'd0);

        // reset while an instruction is live: it must not retire
        dbg_addr = 5'd12;
        send(32'h200C0063, 32'd0, 32'd0, st);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_issue_valid", {31'd0, issue_valid}, 32'd0);
        check("midrst_opcode", {26'd0, opcode}, 32'd0);
        check("midrst_rs_val", rs_val, 32'd0);
        check("midrst_ready", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_no_write", dbg_data, 32'd0);
        dbg_addr = 5'd2;
        #1;
        check("midrst_rf_cleared", dbg_data, 32'd0);
        check("midrst_cnt", {24'd0, retire_cnt}, 32'd0);
        sb_q.delete();
        exp_cnt = '0;
        rst_n   = 1'b1;
        #1;
        check("midrst_ready_release", {31'd0, instr_ready}, 32'd1);
        send(32'h200D0009, 32'd0, 32'd0, st);
        @(posedge clk);
        #1;
        dbg_addr = 5'd13;
        #1;
        check("post_rst_write", dbg_data, 32'd9);
        check("post_rst_cnt", {24'd0, retire_cnt}, 32'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Producer side of the ALU operand interface. Accepts 32-bit MIPS-format instruction words over a valid/ready handshake and reads RS/RT from an internal 32x32 register file. Registers the decoded fields onto the ALU's OPCODE/RS_VAL/RT_VAL/SHAMT/FUNC/RAW_VAL inputs. Writes the ALU's RESULT back one cycle later. Sits between instruction fetch and the combinational ALU, and is the unit the ALU benches will eventually be replaced by.

## Interface
Parameters:
- CNT_W, 16, width of retire counter

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- INSTR  in  32  instruction word
- INSTR_VALID  in  1  INSTR present
- INSTR_READY  out  1  stage can accept INSTR this cycle
- OPCODE  out  6  registered INSTR[31:26]
- RS_VAL  out  32  registered register-file value of INSTR[25:21]
- RT_VAL  out  32  registered register-file value of INSTR[20:16]
- SHAMT  out  5  registered INSTR[10:6]
- FUNC  out  6  registered INSTR[5:0]
- RAW_VAL  out  16  registered INSTR[15:0]
- ISSUE_VALID  out  1  ALU fields hold a live instruction
- RESULT  in  32  ALU result, combinational from the fields above
- SIG_B  in  1  ALU branch condition
- BR_TAKEN  out  1  SIG_B registered at retire of a branch
- DBG_ADDR  in  5  debug register-file read address
- DBG_DATA  out  32  combinational register-file read at DBG_ADDR; reg 0 always reads 0
- RETIRE_CNT  out  CNT_W  retired-instruction count

## Operation
- Accept occurs on a rising edge with INSTR_VALID & INSTR_READY.
  - Fields and RS/RT read values load into the output registers.
  - ISSUE_VALID is set to 1.
- A rising edge with no accept clears ISSUE_VALID to 0. Field registers hold their values.
- Retire occurs on a rising edge with ISSUE_VALID=1.
  - Destination index: rd (INSTR[15:11]) when OPCODE=0, otherwise rt.
  - RESULT is written into the destination register.
  - Write is suppressed when the destination is 0.
  - Write is suppressed when OPCODE is 000100 (beq), 000101 (bne) or 101011 (sw).
  - For beq/bne: BR_TAKEN <= SIG_B. Every other retire: BR_TAKEN <= 0.
  - RETIRE_CNT increments, wrapping from all-ones to 0.
- Register 0 is hardwired to 0. Register-file reads are combinational. A write lands on the edge it is performed.
- RAW hazard: an incoming INSTR whose rs or rt equals the live instruction's write-enabled, non-zero destination. Handling depends on the configuration below.
- INSTR_READY = RST_N & ~stall. Without stall the stage takes one instruction per cycle.
- No backpressure from the ALU side.

## Timing
- Reset (RST_N low, asynchronous): every output register, the register file, ISSUE_VALID, BR_TAKEN and RETIRE_CNT go to 0. INSTR_READY = 0.
- Reset deasserted mid-stream: the in-flight instruction is discarded, not retired. The first accept is possible on the first rising edge with RST_N high.
- Latency from accept edge N:
  - Fields valid after edge N.
  - RESULT written at edge N+1.
  - A dependent read without stall sees the value from edge N+2.
- Back-to-back accept and retire on the same edge: retire uses the old fields; accept loads the new fields.

## Configuration
- Macro: ALU_ISSUE_FWD_EN.
- Defined: hazard operands are taken from RESULT instead of the register file. Stall is never asserted.
- Undefined: hazard asserts stall (INSTR_READY=0) for exactly one cycle. The instruction is accepted on the next edge and reads the written value.

## Test plan
- Reset behaviour: hold RST_N low with INSTR_VALID=1 -> all outputs 0, INSTR_READY=0. Release -> INSTR_READY=1.
- Independent pair: 0x2002000C (addi r2,r0,12), then after 3 idle cycles 0x00021840 (sll r3,r2,1).
  - Second issue: RT_VAL=12, SHAMT=1, FUNC=0.
  - DBG_ADDR=3 reads 24. RETIRE_CNT=2.
- Dependent back-to-back pair, same two words:
  - FWD_EN defined: no stall, RT_VAL=12 on the second issue.
  - FWD_EN undefined: INSTR_READY low for one cycle, RT_VAL=12, total retire one cycle later.
- Zero register: 0x20000005 (addi r0,r0,5) -> DBG_ADDR=0 reads 0, RETIRE_CNT increments.
- Branch: beq with RS_VAL=RT_VAL=0 -> BR_TAKEN=1 for one cycle after retire, no register written.
- Counter wrap and reset mid-operation:
  - Preload via 0xFFFF retires, then one more -> RETIRE_CNT=0.
  - Assert RST_N during ISSUE_VALID=1 -> no write occurs, outputs 0.
